// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array A-operand path.
// Holds the default array geometry, the row loader state encoding and the
// drain-length helper used by the loader and sized against the skew FIFOs.
package sa_pkg;

  localparam int SA_DIM  = 8;
  localparam int SA_BITS = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } loader_state_t;

  // Number of shift cycles needed to empty the deepest skewed FIFO.
  function automatic int drain_cycles(input int dim);
    return (2 * dim) - 1;
  endfunction

endpackage

// File: rtl/row_assembler.sv
// Collects in-order matrix words into a row buffer and, when the last column
// of a row arrives, publishes the complete row as a registered one-cycle,
// row-select FIFO write.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   clr           restart row/column counting at the beginning of a load
//   word_valid    a matrix word is presented on word_data this cycle
//   word_data     matrix word, row-major order
//   fifo_wren     one-hot row write strobe (registered)
//   fifo_d        registered row data, slice k = column k
//   row_done      strobe, high in the cycle a row write is presented
module row_assembler
  import sa_pkg::*;
#(
  parameter int DIM  = SA_DIM,
  parameter int BITS = SA_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                word_valid,
  input  logic [BITS-1:0]     word_data,
  output logic [DIM-1:0]      fifo_wren,
  output logic [DIM*BITS-1:0] fifo_d,
  output logic                row_done
);

  localparam int            IW       = (DIM > 1) ? $clog2(DIM) : 1;
  localparam logic [IW-1:0] LAST_COL = IW'(DIM - 1);

  logic [IW-1:0]       col_q, col_d;
  logic [IW-1:0]       row_q, row_d;
  logic [BITS-1:0]     row_buf_q [DIM];
  logic [BITS-1:0]     row_buf_d [DIM];
  logic [DIM-1:0]      wren_q, wren_d;
  logic [DIM*BITS-1:0] fifo_d_q, fifo_d_d;

  // Row buffer fill and row publication.
  always_comb begin
    col_d     = col_q;
    row_d     = row_q;
    row_buf_d = row_buf_q;
    wren_d    = '0;
    fifo_d_d  = fifo_d_q;
    if (clr) begin
      col_d = '0;
      row_d = '0;
    end else if (word_valid) begin
      if (col_q == LAST_COL) begin
        // The last word bypasses row_buf so the full row is captured now;
        // word 0 of the next row may land in row_buf next cycle without
        // touching the published fifo_d.
        for (int k = 0; k < DIM - 1; k++) begin
          fifo_d_d[k*BITS +: BITS] = row_buf_q[k];
        end
        fifo_d_d[(DIM-1)*BITS +: BITS] = word_data;
        wren_d = DIM'(1) << row_q;
        col_d  = '0;
        row_d  = row_q + IW'(1);
      end else begin
        row_buf_d[col_q] = word_data;
        col_d            = col_q + IW'(1);
      end
    end else begin
      col_d = col_q;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q    <= '0;
      row_q    <= '0;
      wren_q   <= '0;
      fifo_d_q <= '0;
      for (int k = 0; k < DIM; k++) begin
        row_buf_q[k] <= '0;
      end
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      wren_q    <= wren_d;
      fifo_d_q  <= fifo_d_d;
      row_buf_q <= row_buf_d;
    end
  end

  assign fifo_wren = wren_q;
  assign fifo_d    = fifo_d_q;
  assign row_done  = |wren_q;

endmodule

// File: rtl/a_row_loader.sv
// A-operand row loader: on start, reads a DIM x DIM matrix (row-major) from
// memory, writes each assembled row into its skew FIFO, then broadcasts the
// FIFO shift enable long enough to drain every skewed FIFO into the array.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   start        begin a load (accepted only when idle)
//   base_addr    word address of A[0][0], captured with start
//   busy         high whenever not idle
//   done         one-cycle pulse after the final drain cycle
//   mem_req/mem_addr/mem_gnt         read request handshake
//   mem_rvalid/mem_rdata             in-order read responses
//   fifo_wren    one-hot row write strobe
//   fifo_d       row data, slice k = A[r][k]
//   fifo_en      shift enable broadcast to all FIFOs
module a_row_loader
  import sa_pkg::*;
#(
  parameter int DIM  = SA_DIM,
  parameter int BITS = SA_BITS,
  parameter int AW   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [AW-1:0]       base_addr,
  output logic                busy,
  output logic                done,
  output logic                mem_req,
  output logic [AW-1:0]       mem_addr,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [BITS-1:0]     mem_rdata,
  output logic [DIM-1:0]      fifo_wren,
  output logic [DIM*BITS-1:0] fifo_d,
  output logic                fifo_en
);

  localparam int            N          = DIM * DIM;
  localparam int            CW         = $clog2(N + 1);
  localparam logic [CW-1:0] N_WORDS    = CW'(N);
  localparam logic [CW-1:0] LAST_REQ   = CW'(N - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(drain_cycles(DIM) - 1);

  loader_state_t state_q, state_d;
  logic [CW-1:0] req_cnt_q, req_cnt_d;
  logic [CW-1:0] rsp_cnt_q, rsp_cnt_d;
  logic [CW-1:0] drain_cnt_q, drain_cnt_d;
  logic          mem_req_q, mem_req_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          fifo_en_q, fifo_en_d;
  logic          start_accept_s;
  logic          rsp_accept_s;
  logic          row_done_s;

  // Accept qualifiers for start and read responses.
  always_comb begin
    start_accept_s = (state_q == IDLE) && start;
    // Responses outside FETCH (e.g. stragglers after a reset) or beyond the
    // last expected word are dropped.
    rsp_accept_s   = (state_q == FETCH) && mem_rvalid && (rsp_cnt_q != N_WORDS);
  end

  // Next-state, counters and registered outputs.
  always_comb begin
    state_d     = state_q;
    req_cnt_d   = req_cnt_q;
    rsp_cnt_d   = rsp_cnt_q;
    drain_cnt_d = drain_cnt_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;

    if (rsp_accept_s) begin
      rsp_cnt_d = rsp_cnt_q + CW'(1);
    end else begin
      rsp_cnt_d = rsp_cnt_q;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = FETCH;
          req_cnt_d  = '0;
          rsp_cnt_d  = '0;
          mem_req_d  = 1'b1;
          mem_addr_d = base_addr;
        end else begin
          mem_req_d = 1'b0;
        end
      end
      FETCH: begin
        if (mem_req_q && mem_gnt) begin
          req_cnt_d  = req_cnt_q + CW'(1);
          // Address is base + req_cnt kept incrementally; wraps mod 2^AW.
          mem_addr_d = mem_addr_q + AW'(1);
          mem_req_d  = (req_cnt_q != LAST_REQ);
        end else begin
          mem_req_d = mem_req_q;
        end
        // A row strobe with every response consumed is the last row's
        // write; leaving now keeps fifo_wren and fifo_en disjoint.
        if (row_done_s && (rsp_cnt_q == N_WORDS)) begin
          state_d     = DRAIN;
          drain_cnt_d = '0;
        end else begin
          state_d = FETCH;
        end
      end
      DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d = DONE;
        end else begin
          drain_cnt_d = drain_cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered decodes of the upcoming state.
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
    fifo_en_d = (state_d == DRAIN);
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      req_cnt_q   <= '0;
      rsp_cnt_q   <= '0;
      drain_cnt_q <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fifo_en_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_cnt_q   <= req_cnt_d;
      rsp_cnt_q   <= rsp_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fifo_en_q   <= fifo_en_d;
    end
  end

  row_assembler #(
    .DIM  (DIM),
    .BITS (BITS)
  ) u_row_assembler (
    .clk        (clk),
    .rst        (rst),
    .clr        (start_accept_s),
    .word_valid (rsp_accept_s),
    .word_data  (mem_rdata),
    .fifo_wren  (fifo_wren),
    .fifo_d     (fifo_d),
    .row_done   (row_done_s)
  );

  assign busy     = busy_q;
  assign done     = done_q;
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign fifo_en  = fifo_en_q;

endmodule

// File: tb/tb_a_row_loader.sv
// Self-checking bench for a_row_loader (DIM=4, BITS=16). A memory model with
// random grant stalls and latency feeds the DUT; expected rows and request
// addresses are queued when a load is issued and checked by monitors.
// A second instance with AW=8 runs in lockstep to observe address wrap.
module tb_a_row_loader;

  localparam int DIM  = 4;
  localparam int BITS = 16;
  localparam int N    = DIM * DIM;
  localparam int DRN  = 2 * DIM - 1;

  logic                clk = 1'b0;
  logic                rst, start, mem_gnt, mem_rvalid;
  logic [15:0]         base_addr, mem_rdata;
  logic [7:0]          base8;
  logic                busy, done, mem_req, fifo_en;
  logic [15:0]         mem_addr;
  logic [DIM-1:0]      fifo_wren;
  logic [DIM*BITS-1:0] fifo_d;
  logic                w_busy, w_done, w_req, w_en;
  logic [7:0]          w_addr;
  logic [DIM-1:0]      w_wren;
  logic [DIM*BITS-1:0] w_d;

  typedef struct { int ready; logic [15:0] addr; } pend_t;
  pend_t               pend[$];
  logic [DIM-1:0]      exp_wren[$];
  logic [DIM*BITS-1:0] exp_data[$];
  logic [15:0]         exp_addr[$];
  logic [7:0]          exp_addr8[$];

  int          checks = 0, errors = 0;
  int          cyc = 0, grant_total = 0, done_cnt = 0, en_run = 0;
  int          stall_pct = 0, lat_min = 1, lat_max = 1;
  logic [15:0] key = 16'h0000;

  a_row_loader #(.DIM(DIM), .BITS(BITS), .AW(16)) u_dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .busy(busy), .done(done), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .fifo_wren(fifo_wren), .fifo_d(fifo_d), .fifo_en(fifo_en));

  a_row_loader #(.DIM(DIM), .BITS(BITS), .AW(8)) u_wrap (
    .clk(clk), .rst(rst), .start(start), .base_addr(base8),
    .busy(w_busy), .done(w_done), .mem_req(w_req), .mem_addr(w_addr),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .fifo_wren(w_wren), .fifo_d(w_d), .fifo_en(w_en));

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] word_of(input logic [15:0] a);
    return a ^ key;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Reference model: matrix element A[r][k] lives at base + DIM*r + k.
  task automatic push_expected(input logic [15:0] base, input logic [7:0] b8);
    logic [DIM*BITS-1:0] row;
    for (int r = 0; r < DIM; r++) begin
      for (int k = 0; k < DIM; k++) row[k*BITS +: BITS] = word_of(base + 16'(DIM * r + k));
      exp_wren.push_back(DIM'(1) << r);
      exp_data.push_back(row);
    end
    for (int i = 0; i < N; i++) begin
      exp_addr.push_back(base + 16'(i));
      exp_addr8.push_back(b8 + 8'(i));
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_mem_req"}, mem_req, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_fifo_en"}, fifo_en, 0);
    check({tag, "_fifo_wren"}, fifo_wren, 0);
    check({tag, "_fifo_d"}, fifo_d, 0);
  endtask

  // Memory model: grants, address checks, in-order delayed responses.
  logic        prev_stall = 1'b0;
  logic [15:0] prev_addr  = 16'h0000;
  initial begin
    pend_t p;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      cyc++;
      if (prev_stall && mem_req) check("addr_stable_in_stall", mem_addr, prev_addr);
      mem_gnt = ($urandom_range(99) >= stall_pct);
      if (mem_req && mem_gnt) begin
        grant_total++;
        if (exp_addr.size() == 0) check("unexpected_grant", 1, 0);
        else check("grant_addr", mem_addr, exp_addr.pop_front());
        p.ready = cyc + int'($urandom_range(lat_max, lat_min));
        p.addr  = mem_addr;
        pend.push_back(p);
      end
      if (w_req && mem_gnt) begin
        if (exp_addr8.size() == 0) check("unexpected_wrap_grant", 1, 0);
        else check("wrap_grant_addr", w_addr, exp_addr8.pop_front());
      end
      prev_stall = mem_req && !mem_gnt;
      prev_addr  = mem_addr;
      if (pend.size() > 0 && pend[0].ready <= cyc) begin
        mem_rvalid = 1'b1;
        mem_rdata  = word_of(pend[0].addr);
        void'(pend.pop_front());
      end else begin
        mem_rvalid = 1'b0;
        mem_rdata  = 16'($urandom);
      end
    end
  end

  // Output monitor: row writes against the scoreboard, drain length, done.
  initial begin
    forever begin
      @(negedge clk);
      if (fifo_wren != '0) begin
        check("wren_en_overlap", fifo_en, 0);
        check("wrap_lockstep_wren", w_wren, fifo_wren);
        check("wrap_lockstep_data", w_d, fifo_d);
        if (exp_wren.size() == 0) check("unexpected_wren", fifo_wren, 0);
        else begin
          check("row_wren", fifo_wren, exp_wren.pop_front());
          check("row_data", fifo_d, exp_data.pop_front());
        end
      end
      if (fifo_en) en_run++;
      if (done) begin
        done_cnt++;
        check("drain_len", en_run, DRN);
        check("rows_all_written", exp_wren.size(), 0);
        check("wrap_lockstep_done", {w_done, w_busy, w_en}, 3'b110);
        en_run = 0;
      end
    end
  end

  task automatic run_load(input logic [15:0] base, input logic [7:0] b8, input logic [15:0] kk,
                          input int stall, input int lmin, input int lmax,
                          input int exp_cyc, input bit disturb);
    int c0, d0, g0;
    bit seen, pulsed;
    key = kk; stall_pct = stall; lat_min = lmin; lat_max = lmax;
    push_expected(base, b8);
    d0 = done_cnt; g0 = grant_total;
    tick();
    start = 1'b1; base_addr = base; base8 = b8; c0 = cyc;
    seen = 1'b0; pulsed = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      tick();
      start = 1'b0; base_addr = 16'($urandom); base8 = 8'($urandom);
      if (i == 0) check("req_one_cycle_after_start", {mem_req, busy}, 2'b11);
      if (done) begin
        seen = 1'b1;
        if (exp_cyc > 0) check("start_to_done_cycles", cyc - c0, exp_cyc);
      end else if (disturb && (i == 3 || (fifo_en && !pulsed))) begin
        start = 1'b1;
        if (fifo_en) pulsed = 1'b1;
      end
    end
    if (!seen) check("done_timeout", 0, 1);
    repeat (4) tick();
    check("single_done", done_cnt - d0, 1);
    check("grant_count", grant_total - g0, N);
    check("addr_queue_empty", exp_addr.size(), 0);
    check("idle_after_done", busy, 0);
  endtask

  task automatic reset_mid_op();
    int g0;
    key = 16'h0000; stall_pct = 0; lat_min = 3; lat_max = 3;
    push_expected(16'h0100, 8'h00);
    g0 = grant_total;
    tick();
    start = 1'b1; base_addr = 16'h0100; base8 = 8'h00;
    tick();
    start = 1'b0;
    for (int i = 0; i < 100 && (grant_total - g0) < 6; i++) tick();
    check("grants_before_rst", grant_total - g0, 6);
    check("pending_at_rst", pend.size(), 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_zero("mid_rst");
    exp_wren.delete(); exp_data.delete(); exp_addr.delete(); exp_addr8.delete();
    for (int i = 0; i < 20 && pend.size() > 0; i++) tick();
    check("late_rsp_drained", pend.size(), 0);
    repeat (3) tick();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = 16'h0000; base8 = 8'h00;
    repeat (3) tick();
    check_zero("reset");
    rst = 1'b0;
    tick();
    // Basic load, rdata = address, back-to-back responses across rows.
    run_load(16'h0100, 8'h00, 16'h0000, 0, 1, 1, 26, 1'b0);
    // Grant stalls, same data as the basic case.
    run_load(16'h0100, 8'h00, 16'h0000, 50, 1, 1, -1, 1'b0);
    // Start pulsed during FETCH and DRAIN with different base_addr.
    run_load(16'h0100, 8'h00, 16'h0000, 0, 1, 1, 26, 1'b1);
    // Reset with responses outstanding, then a fresh load.
    reset_mid_op();
    run_load(16'h0100, 8'h00, 16'h0000, 0, 1, 1, 26, 1'b0);
    // Address wrap (AW=8 instance at 0xFC, AW=16 instance at 0xFFFC).
    run_load(16'hFFFC, 8'hFC, 16'($urandom), 25, 1, 2, -1, 1'b0);
    // Randomized loads with stalls and variable read latency.
    for (int t = 0; t < 4; t++) begin
      run_load(16'($urandom), 8'($urandom), 16'($urandom), 40, 1, 4, -1, 1'b0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/a_row_loader.md
# a_row_loader

Upstream feeder for the A-operand skewing FIFOs of the systolic matrix multiplier. On `start`, it fetches a DIM×DIM matrix of BITS-wide words from memory in row-major order and assembles each row. It writes each complete row into its FIFO as a one-cycle, row-select write. Once all rows are loaded, it asserts the common FIFO shift enable for the number of cycles needed to drain every skewed FIFO into the array.

## Interface
- `DIM`, 8, matrix dimension; number of rows and FIFOs, and words per row
- `BITS`, 64, data word width
- `AW`, 32, memory address width
- `clk`  in  1  clock; all state updates on its rising edge
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  begin a load; sampled only in IDLE
- `base_addr`  in  AW  word address of A[0][0]; captured on accepted `start`
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse after the final drain cycle
- `mem_req`  out  1  read request valid
- `mem_addr`  out  AW  word address of the current request
- `mem_gnt`  in  1  request accepted this cycle when `mem_req && mem_gnt`
- `mem_rvalid`  in  1  read data valid; responses are in order, one per granted request, no backpressure
- `mem_rdata`  in  BITS  read data
- `fifo_wren`  out  DIM  one-hot row write strobe; bit r writes FIFO r
- `fifo_d`  out  DIM×BITS  registered row data; `fifo_d[k]` = A[r][k]
- `fifo_en`  out  1  shift enable broadcast to all FIFOs

## Operation
- The state machine has four states: IDLE, FETCH, DRAIN, DONE.
- **IDLE → FETCH**
  - Transition happens on `start`.
  - `base_addr` is latched, and the request counter and response counter are cleared.
- **FETCH, requests**
  - `mem_req` stays high until DIM*DIM requests have been granted.
  - `mem_addr` = base + req_cnt.
  - `req_cnt` increments on each grant.
- **FETCH, responses**
  - Each `mem_rvalid` stores `mem_rdata` into row_buf[rsp_cnt % DIM], then `rsp_cnt` increments.
  - When the word with column DIM-1 arrives, the full row (row_buf plus the arriving word) is copied into the `fifo_d` register.
  - On the next cycle, `fifo_wren[rsp_cnt/DIM]` is asserted for exactly one cycle.
  - Word 0 of the next row may arrive in that same cycle. It must not alter the `fifo_d` value being written.
- **FETCH → DRAIN**
  - Transition happens the cycle after the row DIM-1 `fifo_wren` pulse.
  - Therefore `fifo_wren` and `fifo_en` are never high together.
- **DRAIN**
  - `fifo_en` is high for exactly 2*DIM-1 consecutive cycles, counted by a drain counter.
  - This empties FIFO depths up to 2*DIM-1.
- **DONE**
  - `done` is high for one cycle, then the block returns to IDLE.
- **Ignored inputs**
  - `start` is ignored while `busy`.
  - `mem_rvalid` is ignored outside FETCH, and also once rsp_cnt = DIM*DIM.
- **Arithmetic**
  - Counters are $clog2(DIM*DIM+1) bits wide.
  - Address addition is modulo 2^AW; wrap is allowed and is not flagged.

## Timing
- **Reset values:**
  - `busy`, `done`, `mem_req`, `fifo_en` = 0
  - `fifo_wren` = 0
  - `fifo_d` = all zeros
  - `mem_addr` = 0
  - state = IDLE
- **Reset mid-operation:** takes effect on the next edge. The next cycle shows reset values. Outstanding responses arriving afterwards are dropped.
- **`start` to first `mem_req`:** 1 cycle.
- **Request rules:**
  - `mem_addr` is stable while `mem_req && !mem_gnt`.
  - A new address is presented in the cycle after a grant.
  - With `mem_gnt` held high, one request is granted per cycle.
- **Write latency:** the last `mem_rvalid` of a row is followed by `fifo_wren` exactly 1 cycle later.
- **Minimum total, with `mem_gnt`=1 and read latency L:** 1 + DIM*DIM + L + 1 + (2*DIM-1) cycles from `start` to `done`.

## Structure
- Package `sa_pkg` holds:
  - `loader_state_t` enum (IDLE, FETCH, DRAIN, DONE)
  - function `drain_cycles(dim)` = 2*dim-1
  - shared DIM/BITS defaults used by the FIFOs and the array
- One natural sub-module: `row_assembler`. It contains row_buf, the column counter, and the registered `fifo_d`/`fifo_wren` output, with a row-complete strobe.

## Test plan
- **Basic load.** Setup: DIM=4, BITS=16, base 0x100, `mem_gnt`=1, read latency 1, rdata = address. Required response:
  - `fifo_wren` pulses 0001, 0010, 0100, 1000 in order.
  - Row r shows `fifo_d[k]` = 0x100+4r+k.
  - Then `fifo_en` is high for 7 cycles, then `done` for 1 cycle.
  - `done` arrives 26 cycles after `start`.
- **Grant stalls.** Setup: random `mem_gnt` with 50% stalls. Required response:
  - `mem_addr` is constant throughout each stall.
  - Exactly 16 grants occur, at addresses 0x100–0x10F.
  - Row data is identical to the basic-load case.
- **Row boundary.** Setup: back-to-back `mem_rvalid` across a row boundary. Required response: the row 0 write carries 0x100–0x103, uncorrupted by 0x104 arriving in the same cycle.
- **Start while busy.** Setup: `start` pulsed during FETCH and during DRAIN. Required response:
  - No restart.
  - A single `done`.
  - `base_addr` changes are not picked up.
- **Reset mid-operation.** Setup: `rst` asserted after 6 grants, with 3 responses still pending. Required response:
  - Next cycle shows all outputs at zero.
  - Late `mem_rvalid` causes no `fifo_wren`.
  - A fresh `start` completes correctly.
- **Address wrap.** Setup: AW=8, base 0xFC. Required response: requests go to 0xFC–0xFF, then 0x00–0x0B, all in order.
